// File: rtl/cv32e40s_rvfi_retire_sched.sv
// RVFI retirement scheduler: in-order FIFO of WB retirement records with
// order numbering and attachment of pending trap-entry (rvfi_intr_t) info.
module cv32e40s_rvfi_retire_sched #(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_valid_i,
  input  logic [31:0]            wb_pc_i,
  input  logic [31:0]            wb_instr_i,
  input  logic [13:0]            wb_trap_i,
  input  logic                   intr_event_i,
  input  logic                   intr_is_irq_i,
  input  logic [10:0]            intr_cause_i,
  input  logic                   rvfi_ready_i,
  output logic                   rvfi_valid_o,
  output logic [ORDER_W-1:0]     rvfi_order_o,
  output logic [31:0]            rvfi_pc_rdata_o,
  output logic [31:0]            rvfi_insn_o,
  output logic [13:0]            rvfi_trap_o,
  output logic [13:0]            rvfi_intr_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        pc;
    logic [31:0]        insn;
    logic [13:0]        trap;
    logic [13:0]        intr;
  } rec_t;

  // rvfi_intr_t: {cause, interrupt, exception, intr}
  function automatic logic [13:0] form_intr(input logic [10:0] cause, input logic is_irq);
    return {cause, is_irq, ~is_irq, 1'b1};
  endfunction

  rec_t               mem_r [DEPTH];
  logic [AW-1:0]      rd_ptr_r;
  logic [AW-1:0]      wr_ptr_r;
  logic [CW-1:0]      count_r;
  logic [ORDER_W-1:0] order_r;
  logic [13:0]        pend_intr_r;
  logic               overflow_r;

  logic               full_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic [13:0]        new_intr_s;
  logic [13:0]        rec_intr_s;
  rec_t               new_rec_s;
  rec_t               head_s;

  // Handshake decode and formation of the record to be pushed
  always_comb begin
    full_s     = (count_r == CW'(DEPTH));
    pop_s      = (count_r != {CW{1'b0}}) && rvfi_ready_i;
    push_s     = wb_valid_i && (!full_s || pop_s);
    drop_s     = wb_valid_i && !push_s;
    new_intr_s = form_intr(intr_cause_i, intr_is_irq_i);
    // A trap entered in the same cycle marks this as the handler's first instruction
    if (intr_event_i) begin
      rec_intr_s = new_intr_s;
    end else begin
      rec_intr_s = pend_intr_r;
    end
    new_rec_s       = '0;
    new_rec_s.order = order_r;
    new_rec_s.pc    = wb_pc_i;
    new_rec_s.insn  = wb_instr_i;
    new_rec_s.trap  = wb_trap_i;
    new_rec_s.intr  = rec_intr_s;
  end

  // FIFO storage, pointers, occupancy, order counter, pending intr, sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      order_r     <= '0;
      pend_intr_r <= 14'd0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= new_rec_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
        order_r         <= order_r + ORDER_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // Dropped pushes keep the pending intr; the latest trap overwrites it
      if (push_s) begin
        pend_intr_r <= 14'd0;
      end else if (intr_event_i) begin
        pend_intr_r <= new_intr_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Head record drive; payload forced to zero when empty
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (count_r != {CW{1'b0}}) begin
      rvfi_valid_o    = 1'b1;
      rvfi_order_o    = head_s.order;
      rvfi_pc_rdata_o = head_s.pc;
      rvfi_insn_o     = head_s.insn;
      rvfi_trap_o     = head_s.trap;
      rvfi_intr_o     = head_s.intr;
    end else begin
      rvfi_valid_o    = 1'b0;
      rvfi_order_o    = '0;
      rvfi_pc_rdata_o = 32'd0;
      rvfi_insn_o     = 32'd0;
      rvfi_trap_o     = 14'd0;
      rvfi_intr_o     = 14'd0;
    end
  end

  assign count_o    = count_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_cv32e40s_rvfi_retire_sched.sv
// Bench for cv32e40s_rvfi_retire_sched: vector table, directed corner
// sequences and a queue-based reference model under random stimulus.
module tb_cv32e40s_rvfi_retire_sched;

  localparam int DEPTH   = 4;
  localparam int ORDER_W = 64;

  logic               clk;
  logic               rst;
  logic               wb_valid;
  logic [31:0]        wb_pc;
  logic [31:0]        wb_instr;
  logic [13:0]        wb_trap;
  logic               intr_event;
  logic               intr_is_irq;
  logic [10:0]        intr_cause;
  logic               rvfi_ready;
  logic               rvfi_valid;
  logic [ORDER_W-1:0] rvfi_order;
  logic [31:0]        rvfi_pc_rdata;
  logic [31:0]        rvfi_insn;
  logic [13:0]        rvfi_trap;
  logic [13:0]        rvfi_intr;
  logic [2:0]         count;
  logic               overflow;

  cv32e40s_rvfi_retire_sched #(.DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid_i     (wb_valid),
    .wb_pc_i        (wb_pc),
    .wb_instr_i     (wb_instr),
    .wb_trap_i      (wb_trap),
    .intr_event_i   (intr_event),
    .intr_is_irq_i  (intr_is_irq),
    .intr_cause_i   (intr_cause),
    .rvfi_ready_i   (rvfi_ready),
    .rvfi_valid_o   (rvfi_valid),
    .rvfi_order_o   (rvfi_order),
    .rvfi_pc_rdata_o(rvfi_pc_rdata),
    .rvfi_insn_o    (rvfi_insn),
    .rvfi_trap_o    (rvfi_trap),
    .rvfi_intr_o    (rvfi_intr),
    .count_o        (count),
    .overflow_o     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb_valid   = 1'b0;
    wb_pc      = 32'd0;
    wb_instr   = 32'd0;
    wb_trap    = 14'd0;
    intr_event = 1'b0;
    intr_is_irq = 1'b0;
    intr_cause = 11'd0;
  endtask

  task automatic retire(input logic [31:0] pc);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_instr = ~pc;
    wb_trap  = pc[15:2];
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        wbv;
    logic [31:0] pc;
    logic        rdy;
    logic        ev;
    logic        irq;
    logic [10:0] cause;
    logic        exp_v;
    logic [63:0] exp_o;
    logic [31:0] exp_pc;
    logic [13:0] exp_intr;
    logic [2:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic wbv, input logic [31:0] pc,
                               input logic rdy, input logic ev, input logic irq,
                               input logic [10:0] cause, input logic ev_v,
                               input logic [63:0] eo, input logic [31:0] epc,
                               input logic [13:0] ei, input logic [2:0] ec, input logic eovf);
    vec_t v;
    v.rst = r; v.wbv = wbv; v.pc = pc; v.rdy = rdy; v.ev = ev; v.irq = irq; v.cause = cause;
    v.exp_v = ev_v; v.exp_o = eo; v.exp_pc = epc; v.exp_intr = ei; v.exp_cnt = ec; v.exp_ovf = eovf;
    return v;
  endfunction

  vec_t vecs [17];

  typedef struct {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [13:0] trap;
    logic [13:0] intr;
  } mrec_t;

  mrec_t       q[$];
  logic [63:0] m_order;
  logic [13:0] m_pend;
  logic        m_ovf;

  initial begin
    rst = 1'b1;
    rvfi_ready = 1'b1;
    idle_in();

    // ---------------- vector table ----------------
    vecs[0]  = mkv(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 11'd0,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[1]  = mkv(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 64'd0, 32'h100, 14'd0,  3'd1, 1'b0);
    vecs[2]  = mkv(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 64'd1, 32'h104, 14'd0,  3'd1, 1'b0);
    vecs[3]  = mkv(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 64'd2, 32'h108, 14'd0,  3'd1, 1'b0);
    vecs[4]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 11'd0,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[5]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 11'd11, 1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[6]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 11'd0,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[7]  = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 11'd0,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[8]  = mkv(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 64'd3, 32'h200, 14'd93, 3'd1, 1'b0);
    vecs[9]  = mkv(1'b0, 1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 64'd4, 32'h204, 14'd0,  3'd1, 1'b0);
    vecs[10] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 11'd0,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[11] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 11'd7,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[12] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 11'd1,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[13] = mkv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 11'd0,  1'b1, 64'd5, 32'h300, 14'd11, 3'd1, 1'b0);
    vecs[14] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 11'd0,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);
    vecs[15] = mkv(1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 11'd2,  1'b1, 64'd6, 32'h400, 14'd19, 3'd1, 1'b0);
    vecs[16] = mkv(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 11'd0,  1'b0, 64'd0, 32'h0,   14'd0,  3'd0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      rst        = vecs[i].rst;
      wb_valid   = vecs[i].wbv;
      wb_pc      = vecs[i].pc;
      wb_instr   = ~vecs[i].pc;
      wb_trap    = vecs[i].pc[15:2];
      rvfi_ready = vecs[i].rdy;
      intr_event = vecs[i].ev;
      intr_is_irq = vecs[i].irq;
      intr_cause = vecs[i].cause;
      cyc();
      chk($sformatf("vec%0d_valid", i), rvfi_valid,    vecs[i].exp_v);
      chk($sformatf("vec%0d_order", i), rvfi_order,    vecs[i].exp_o);
      chk($sformatf("vec%0d_pc", i),    rvfi_pc_rdata, vecs[i].exp_pc);
      chk($sformatf("vec%0d_intr", i),  rvfi_intr,     vecs[i].exp_intr);
      chk($sformatf("vec%0d_count", i), count,         vecs[i].exp_cnt);
      chk($sformatf("vec%0d_ovf", i),   overflow,      vecs[i].exp_ovf);
    end

    // ---------------- overflow: 5 pushes into DEPTH=4 with ready low ----------------
    do_reset();
    rvfi_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      retire(32'h500 + 32'(4 * i));
      cyc();
    end
    idle_in();
    chk("ovf_count", count, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_drain_order%0d", k), rvfi_order, 64'(k));
      chk($sformatf("ovf_drain_pc%0d", k), rvfi_pc_rdata, 32'h500 + 32'(4 * k));
      rvfi_ready = 1'b1;
      cyc();
    end
    chk("ovf_empty_valid", rvfi_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    retire(32'h600);
    cyc();
    idle_in();
    chk("ovf_next_order", rvfi_order, 64'd4);
    chk("ovf_sticky2", overflow, 1'b1);
    cyc();

    // ---------------- full FIFO, simultaneous push and pop ----------------
    do_reset();
    rvfi_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retire(32'h800 + 32'(4 * i));
      cyc();
    end
    rvfi_ready = 1'b1;
    retire(32'h810);
    cyc();
    idle_in();
    chk("fullpp_count", count, 3'd4);
    chk("fullpp_ovf", overflow, 1'b0);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("fullpp_order%0d", k), rvfi_order, 64'(k));
      cyc();
    end
    chk("fullpp_empty", rvfi_valid, 1'b0);

    // ---------------- asynchronous reset mid-operation ----------------
    do_reset();
    rvfi_ready = 1'b0;
    retire(32'h600); cyc();
    retire(32'h604); cyc();
    idle_in();
    intr_event = 1'b1; intr_is_irq = 1'b1; intr_cause = 11'd5;
    cyc();
    idle_in();
    rst = 1'b1;
    #1;
    chk("rst_async_valid", rvfi_valid, 1'b0);
    chk("rst_async_count", count, 3'd0);
    chk("rst_async_pc", rvfi_pc_rdata, 32'h0);
    cyc();
    rst = 1'b0;
    retire(32'h700);
    cyc();
    idle_in();
    chk("rst_next_order", rvfi_order, 64'd0);
    chk("rst_next_intr", rvfi_intr, 14'd0);
    chk("rst_next_pc", rvfi_pc_rdata, 32'h700);

    // ---------------- random stimulus against a queue model ----------------
    do_reset();
    q.delete();
    m_order = 64'd0;
    m_pend  = 14'd0;
    m_ovf   = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      logic        r_rst;
      logic        pop;
      logic        push;
      logic [13:0] newi;
      logic [191:0] exp_v;
      mrec_t       rec;
      int          thr;
      thr = (k / 200) % 5;
      r_rst       = ($urandom_range(0, 299) == 0);
      rst         = r_rst;
      wb_valid    = ($urandom_range(0, 2) != 0);
      wb_pc       = $urandom;
      wb_instr    = $urandom;
      wb_trap     = 14'($urandom);
      rvfi_ready  = ($urandom_range(0, 3) < thr);
      intr_event  = ($urandom_range(0, 7) == 0);
      intr_is_irq = 1'($urandom);
      intr_cause  = 11'($urandom);
      if (r_rst) begin
        q.delete();
        m_order = 64'd0;
        m_pend  = 14'd0;
        m_ovf   = 1'b0;
      end else begin
        newi = {intr_cause, intr_is_irq, ~intr_is_irq, 1'b1};
        pop  = (q.size() > 0) && rvfi_ready;
        push = wb_valid && ((q.size() < DEPTH) || pop);
        if (pop) void'(q.pop_front());
        if (push) begin
          rec.order = m_order;
          rec.pc    = wb_pc;
          rec.insn  = wb_instr;
          rec.trap  = wb_trap;
          rec.intr  = intr_event ? newi : m_pend;
          q.push_back(rec);
          m_order = m_order + 64'd1;
          m_pend  = 14'd0;
        end else if (intr_event) begin
          m_pend = newi;
        end
        if (wb_valid && !push) m_ovf = 1'b1;
      end
      cyc();
      if (q.size() > 0) begin
        exp_v = {1'b1, 3'(q.size()), m_ovf, q[0].order, q[0].pc, q[0].insn, q[0].trap, q[0].intr};
      end else begin
        exp_v = {1'b0, 3'd0, m_ovf, 64'd0, 32'd0, 32'd0, 14'd0, 14'd0};
      end
      chk($sformatf("rand%0d", k),
          {rvfi_valid, count, overflow, rvfi_order, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_intr},
          exp_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
